// File: rtl/plaintext_burst_encryptor.sv
// Button-started sequencer: ROM word -> modexp engine -> ciphertext, single-word or burst.
// Latency ROM_LATENCY+2 cycles per word plus engine time; waits on eng_done, no output backpressure.
module plaintext_burst_encryptor #(
   parameter int DATAWIDTH   = 8,
   parameter int DATADEPTH   = 16,
   parameter int ADDRWIDTH   = 4,
   parameter int ROM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn,
   input  logic                 burst,
   input  logic                 abort,
   output logic                 rom_en,
   output logic [ADDRWIDTH-1:0] rom_addr,
   input  logic [DATAWIDTH-1:0] rom_data,
   output logic                 eng_en,
   output logic [DATAWIDTH-1:0] eng_plain,
   input  logic [DATAWIDTH-1:0] eng_cipher,
   input  logic                 eng_done,
   output logic [DATAWIDTH-1:0] cipher_out,
   output logic [ADDRWIDTH-1:0] cipher_addr,
   output logic                 cipher_valid,
   output logic                 busy,
   output logic                 burst_done
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ROM_WAIT = 2'd1;
   localparam logic [1:0] S_ENC_RUN  = 2'd2;
   localparam logic [1:0] S_ENC_DONE = 2'd3;

   localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DATADEPTH - 1);
   localparam logic [2:0]           LAT_LAST  = 3'(ROM_LATENCY - 1);

   logic                 btn_meta;
   logic                 btn_sync;
   logic                 btn_prev;
   logic                 start;
   logic [1:0]           state;
   logic                 burst_q;
   logic [2:0]           lat_cnt;
   logic [ADDRWIDTH-1:0] addr;
   logic                 last_addr;

   // start is registered so it lands two edges after the button is first sampled
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_prev <= 1'b0;
         start    <= 1'b0;
      end else begin
         btn_meta <= btn;
         btn_sync <= btn_meta;
         btn_prev <= btn_sync;
         start    <= btn_sync & ~btn_prev;
      end
   end

   assign last_addr = (addr == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         burst_q     <= 1'b0;
         lat_cnt     <= 3'd0;
         addr        <= '0;
         eng_plain   <= '0;
         cipher_out  <= '0;
         cipher_addr <= '0;
      end else if (abort && (state != S_IDLE)) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  burst_q <= burst;
                  lat_cnt <= 3'd0;
                  state   <= S_ROM_WAIT;
               end
            end
            S_ROM_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  eng_plain <= rom_data;
                  state     <= S_ENC_RUN;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            S_ENC_RUN: begin
               if (eng_done) begin
                  cipher_out  <= eng_cipher;
                  cipher_addr <= addr;
                  state       <= S_ENC_DONE;
               end
            end
            S_ENC_DONE: begin
               addr    <= last_addr ? '0 : addr + 1'b1;
               lat_cnt <= 3'd0;
               state   <= (burst_q && !last_addr) ? S_ROM_WAIT : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rom_en       = (state == S_ROM_WAIT);
   assign eng_en       = (state == S_ENC_RUN);
   assign cipher_valid = (state == S_ENC_DONE);
   assign busy         = (state != S_IDLE);
   assign burst_done   = cipher_valid && burst_q && last_addr;
   assign rom_addr     = addr;

endmodule

// File: doc/plaintext_burst_encryptor.md
# plaintext_burst_encryptor

Parametrised sequencer that fetches plaintext words from the synchronous plaintext ROM, hands each one to the external modular-exponentiation engine, and presents the resulting ciphertext with its source address. It supersedes the single-word button-driven path: one clock domain, on-chip button synchronisation, configurable ROM latency, and a burst mode that encrypts all DATADEPTH words from one press. It sits between the board push-button, the plaintext ROM and the encryption engine, and feeds the transmit path.

## Interface
- DATAWIDTH, 8, plaintext and ciphertext word width
- DATADEPTH, 16, number of ROM words; addresses 0..DATADEPTH-1
- ADDRWIDTH, 4, ROM address width; must satisfy 2^ADDRWIDTH >= DATADEPTH
- ROM_LATENCY, 2, cycles from the first rom_en edge until rom_data is valid (1..7)
- clk  in  1  single system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-low reset
- btn  in  1  raw push-button, asynchronous to clk
- burst  in  1  mode select, sampled at start: 0 = one word per press, 1 = all words from the current address through DATADEPTH-1
- abort  in  1  return to IDLE without advancing the address
- rom_en  out  1  ROM enable
- rom_addr  out  ADDRWIDTH  ROM address; equals the current address register
- rom_data  in  DATAWIDTH  ROM read data
- eng_en  out  1  engine enable; held high for the whole calculation
- eng_plain  out  DATAWIDTH  plaintext to the engine; stable while eng_en = 1
- eng_cipher  in  DATAWIDTH  engine result; valid when eng_done = 1
- eng_done  in  1  engine completion (level or pulse)
- cipher_out  out  DATAWIDTH  last captured ciphertext
- cipher_addr  out  ADDRWIDTH  address that produced cipher_out
- cipher_valid  out  1  one-cycle pulse per new ciphertext
- busy  out  1  high in every state except IDLE
- burst_done  out  1  one-cycle pulse when the final word of a burst is emitted

## Operation
- Button path: two-flop synchroniser followed by a rising-edge detector giving a one-cycle `start`. Holding the button produces one start only. A start outside IDLE is dropped, not queued.
- States and transitions:
  - IDLE: outputs idle. On `start`, latch `burst` into burst_q and go to ROM_WAIT.
  - ROM_WAIT: rom_en = 1 and a latency counter runs. After ROM_LATENCY cycles in this state, capture rom_data into the eng_plain register and go to ENC_RUN.
  - ENC_RUN: rom_en = 0 and eng_en = 1. On eng_done, capture eng_cipher into cipher_out, capture the address into cipher_addr, and go to ENC_DONE.
  - ENC_DONE: eng_en = 0 for exactly one cycle. cipher_valid = 1. The address advances, wrapping from DATADEPTH-1 to 0. Next state:
    - ROM_WAIT if burst_q = 1 and the emitted address was not DATADEPTH-1.
    - Otherwise IDLE. burst_done = 1 in this cycle when burst_q = 1.
- eng_done outside ENC_RUN is ignored.
- abort (any state except IDLE): next state is IDLE, rom_en and eng_en drop the next cycle, and the address, cipher_out and cipher_addr are unchanged. abort wins over eng_done or start in the same cycle.
- Arithmetic: the address counter is ADDRWIDTH bits and is compared against DATADEPTH-1. It never takes a value >= DATADEPTH.
- Reset values (rst = 0): state IDLE; rom_en, eng_en, cipher_valid, busy and burst_done = 0; address, rom_addr, cipher_out, cipher_addr and eng_plain = 0; synchroniser flops = 0. Reset applied mid-operation takes effect at the next edge regardless of state.

## Timing
- Button to busy: btn high before edge k gives start at edge k+2, and busy plus rom_en high after edge k+3.
- rom_en is high for exactly ROM_LATENCY cycles per word. rom_addr is stable for that whole window.
- eng_en rises on the edge after the ROM capture and is held until the edge after eng_done is seen.
- cipher_valid goes high on the edge after eng_done and stays high for one cycle.
- Per-word overhead excluding engine time is ROM_LATENCY + 2 cycles.
- In a burst, eng_en is low for at least ROM_LATENCY + 1 cycles between words. Engines that clear on eng_en low rely on this.

## Test plan
- Single press, ROM_LATENCY = 2, ROM[0] = 0x05, engine returns 0x9A after 20 cycles: cipher_valid pulses once with cipher_out = 0x9A and cipher_addr = 0. Address becomes 1, rom_en was high for exactly 2 cycles, and busy falls.
- Button held for 500 cycles, then a second press while busy: exactly one word is processed per press, and the press during busy produces nothing.
- burst = 1 from address 13, DATADEPTH = 16: exactly 3 cipher_valid pulses with addresses 13, 14, 15. burst_done coincides with the third pulse, and the address wraps to 0.
- Single mode at address 15: after one word the address is 0. A following press reads ROM[0].
- abort asserted mid-ENC_RUN at address 7, with eng_done in the same cycle: no cipher_valid, address stays 7, eng_en is low the next cycle, and busy is low.
- rst = 0 during ROM_WAIT in a burst: all outputs equal their reset values on the next edge, and a new press starts from address 0.
